// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg
// Shared types and constants for the instruction-memory port arbiter.
// The owner encoding tags every memory read so the returning word can be
// routed back to the port that asked for it.
// Contents:
//   owner_e              owner encoding (fetch / debug)
//   tag_t                {valid, owner} record carried down the tag pipeline
//   READ_LAT_DEFAULT     default memory read latency
//   STARVE_LIMIT_DEFAULT default starvation-guard threshold
package imem_arb_pkg;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DBG   = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam int READ_LAT_DEFAULT     = 1;
    localparam int STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/imem_tag_pipe.sv
// imem_tag_pipe
// DEPTH-stage shift register of {valid, owner} tags. It runs in lock-step
// with the memory read pipeline so the tag leaving the last stage describes
// the word currently on the memory output.
// Ports:
//   clk       system clock
//   rst       synchronous active-high clear (all stages invalid)
//   in_valid  a read was issued this cycle
//   in_owner  owner of that read (OWNER_FETCH / OWNER_DBG)
//   out_valid last stage holds a live read
//   out_owner owner of the last-stage read
module imem_tag_pipe
    import imem_arb_pkg::*;
#(
    parameter int DEPTH = READ_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    tag_t stages [DEPTH];

    // Every stage shifts every cycle, so a tag always takes exactly DEPTH
    // cycles to emerge; clearing all stages drops reads that are in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= '{valid: in_valid, owner: owner_e'(in_owner)};
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_valid = stages[DEPTH-1].valid;
    assign out_owner = stages[DEPTH-1].owner;

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single-port instruction-memory block RAM between the CPU fetch
// stage and the debug/display read port. Fetch has fixed priority; a
// starvation guard forces a debug read through after STARVE_LIMIT
// consecutive denied cycles (STARVE_LIMIT = 0 turns the guard off).
// Returning words are routed by a tag pipeline matched to READ_LAT.
// Optional build macro: IMEM_ARB_STATS_EN adds 16-bit grant counters.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   fetch_req/fetch_addr/fetch_gnt   fetch request, address, grant
//   fetch_rvalid/fetch_rdata         fetch response valid and data
//   dbg_req/dbg_addr/dbg_gnt         debug request, address, grant
//   dbg_rvalid/dbg_rdata             debug response valid and data
//   mem_en/mem_addr/mem_dout         block RAM enable, address, data out
//   stat_fetch_cnt/stat_dbg_cnt/stat_force_cnt  grant counters (macro only)
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LAT     = READ_LAT_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_fetch_cnt,
    output logic [15:0]       stat_dbg_cnt,
    output logic [15:0]       stat_force_cnt
`endif
);

    // A zero limit still needs a one-bit counter to keep the code legal.
    localparam int              CNT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam bit              GUARD_EN = (STARVE_LIMIT != 0);

    logic [CNT_W-1:0]  starve_cnt;
    logic              force_dbg;
    logic [ADDR_W-1:0] last_addr;
    logic              tag_valid;
    logic              tag_owner;
    logic [DATA_W-1:0] fetch_hold;
    logic [DATA_W-1:0] dbg_hold;

    // Grants are gated by rst so requests made during reset never reach
    // the memory or the tag pipeline.
    always_comb begin
        force_dbg = GUARD_EN && (starve_cnt == LIMIT) && dbg_req && !rst;
        fetch_gnt = !rst && fetch_req && !force_dbg;
        dbg_gnt   = !rst && dbg_req && (force_dbg || !fetch_req);
        mem_en    = fetch_gnt | dbg_gnt;
        if (fetch_gnt) begin
            mem_addr = fetch_addr;
        end else if (dbg_gnt) begin
            mem_addr = dbg_addr;
        end else begin
            mem_addr = last_addr;
        end
    end

    // Counts consecutive denied debug cycles, saturating at the limit so the
    // forced grant fires on the cycle after STARVE_LIMIT denials.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Remembers the last issued address so mem_addr stays quiet when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
        end else if (mem_en) begin
            last_addr <= mem_addr;
        end
    end

    imem_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_en),
        .in_owner  (dbg_gnt),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    // A read landing while rst is high belongs to a grant issued before the
    // reset and must be discarded.
    always_comb begin
        fetch_rvalid = !rst && tag_valid && (tag_owner == OWNER_FETCH);
        dbg_rvalid   = !rst && tag_valid && (tag_owner == OWNER_DBG);
    end

    // Each port presents the memory word in its rvalid cycle and keeps a
    // registered copy so the word stays stable until its next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_hold <= '0;
            dbg_hold   <= '0;
        end else begin
            if (fetch_rvalid) begin
                fetch_hold <= mem_dout;
            end
            if (dbg_rvalid) begin
                dbg_hold <= mem_dout;
            end
        end
    end

    assign fetch_rdata = fetch_rvalid ? mem_dout : fetch_hold;
    assign dbg_rdata   = dbg_rvalid   ? mem_dout : dbg_hold;

`ifdef IMEM_ARB_STATS_EN
    // Free-running grant counters; they wrap naturally at 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetch_cnt <= '0;
            stat_dbg_cnt   <= '0;
            stat_force_cnt <= '0;
        end else begin
            if (fetch_gnt) begin
                stat_fetch_cnt <= stat_fetch_cnt + 16'd1;
            end
            if (dbg_gnt) begin
                stat_dbg_cnt <= stat_dbg_cnt + 16'd1;
            end
            if (force_dbg) begin
                stat_force_cnt <= stat_force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Drives three arbiter instances from shared request inputs:
//   dut_a  READ_LAT=1, STARVE_LIMIT=8
//   dut_b  READ_LAT=3, STARVE_LIMIT=0
//   dut_c  READ_LAT=2, STARVE_LIMIT=8
// Each instance has its own block-RAM model whose contents come from
// mem_word(). Inputs change on the falling edge and outputs are sampled
// 1 ns later, well away from the rising edge.
module tb_imem_port_arbiter;
    import imem_arb_pkg::*;

    typedef struct {
        logic        fetch_req;
        logic [9:0]  fetch_addr;
        logic        dbg_req;
        logic [9:0]  dbg_addr;
        logic [4:0]  exp_flags;
        logic [9:0]  exp_addr;
        logic [31:0] exp_frd;
        logic [31:0] exp_drd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [9:0]  fetch_addr;
    logic        dbg_req;
    logic [9:0]  dbg_addr;

    logic        fg_a, dg_a, frv_a, drv_a, en_a;
    logic [31:0] frd_a, drd_a, dout_a;
    logic [9:0]  ma_a;
    logic        fg_b, dg_b, frv_b, drv_b, en_b;
    logic [31:0] frd_b, drd_b, dout_b;
    logic [9:0]  ma_b;
    logic        fg_c, dg_c, frv_c, drv_c, en_c;
    logic [31:0] frd_c, drd_c, dout_c;
    logic [9:0]  ma_c;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] sf_a, sd_a, sx_a, sf_b, sd_b, sx_b, sf_c, sd_c, sx_c;
`endif

    logic [31:0] qa1;
    logic [31:0] qb1, qb2, qb3;
    logic [31:0] qc1, qc2;

    int checks = 0;
    int errors = 0;

    vec_t vec_a [10];
    vec_t vec_b [7];

    always #5 clk = ~clk;

    // Distinct, address-dependent contents for every memory word.
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {a[7:0] ^ 8'hA5, 8'h3C, 6'd0, a};
    endfunction

    function automatic vec_t mk(input logic fq, input int fa, input logic dq, input int da,
                                input logic [4:0] fl, input int ea,
                                input logic [31:0] efd, input logic [31:0] edd);
        vec_t v;
        v.fetch_req  = fq;
        v.fetch_addr = fa[9:0];
        v.dbg_req    = dq;
        v.dbg_addr   = da[9:0];
        v.exp_flags  = fl;
        v.exp_addr   = ea[9:0];
        v.exp_frd    = efd;
        v.exp_drd    = edd;
        return v;
    endfunction

    function automatic logic [127:0] pack_out(input logic fg, input logic dg, input logic en,
                                              input logic frv, input logic drv,
                                              input logic [9:0] a,
                                              input logic [31:0] fd, input logic [31:0] dd);
        return {49'd0, fg, dg, en, frv, drv, a, fd, dd};
    endfunction

    // Block-RAM models: enable-gated registered read, extra output
    // registers for the longer latencies.
    always @(posedge clk) begin
        if (en_a) qa1 <= mem_word(ma_a);
        if (en_b) qb1 <= mem_word(ma_b);
        qb2 <= qb1;
        qb3 <= qb2;
        if (en_c) qc1 <= mem_word(ma_c);
        qc2 <= qc1;
    end
    assign dout_a = qa1;
    assign dout_b = qb3;
    assign dout_c = qc2;

    imem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1), .STARVE_LIMIT(8)) dut_a (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fg_a),
        .fetch_rvalid(frv_a), .fetch_rdata(frd_a),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dg_a),
        .dbg_rvalid(drv_a), .dbg_rdata(drd_a),
        .mem_en(en_a), .mem_addr(ma_a), .mem_dout(dout_a)
`ifdef IMEM_ARB_STATS_EN
        , .stat_fetch_cnt(sf_a), .stat_dbg_cnt(sd_a), .stat_force_cnt(sx_a)
`endif
    );

    imem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(3), .STARVE_LIMIT(0)) dut_b (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fg_b),
        .fetch_rvalid(frv_b), .fetch_rdata(frd_b),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dg_b),
        .dbg_rvalid(drv_b), .dbg_rdata(drd_b),
        .mem_en(en_b), .mem_addr(ma_b), .mem_dout(dout_b)
`ifdef IMEM_ARB_STATS_EN
        , .stat_fetch_cnt(sf_b), .stat_dbg_cnt(sd_b), .stat_force_cnt(sx_b)
`endif
    );

    imem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LAT(2), .STARVE_LIMIT(8)) dut_c (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fg_c),
        .fetch_rvalid(frv_c), .fetch_rdata(frd_c),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dg_c),
        .dbg_rvalid(drv_c), .dbg_rdata(drd_c),
        .mem_en(en_c), .mem_addr(ma_c), .mem_dout(dout_c)
`ifdef IMEM_ARB_STATS_EN
        , .stat_fetch_cnt(sf_c), .stat_dbg_cnt(sd_c), .stat_force_cnt(sx_c)
`endif
    );

    // Moves to the next falling edge, drives one cycle of inputs and
    // leaves 1 ns for the combinational outputs to settle.
    task automatic applyStimulus(input logic r, input logic fq, input logic [9:0] fa,
                                 input logic dq, input logic [9:0] da);
        @(negedge clk);
        rst        = r;
        fetch_req  = fq;
        fetch_addr = fa;
        dbg_req    = dq;
        dbg_addr   = da;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Watchdog so a broken build can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before the test ended");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Fetch-only then debug-only traffic on dut_a (READ_LAT=1).
        // flags = {fetch_gnt, dbg_gnt, mem_en, fetch_rvalid, dbg_rvalid}
        vec_a[0] = mk(1, 0, 0, 0, 5'b10100, 0, 32'd0,        32'd0);
        vec_a[1] = mk(1, 1, 0, 0, 5'b10110, 1, mem_word(0),  32'd0);
        vec_a[2] = mk(1, 2, 0, 0, 5'b10110, 2, mem_word(1),  32'd0);
        vec_a[3] = mk(1, 3, 0, 0, 5'b10110, 3, mem_word(2),  32'd0);
        vec_a[4] = mk(0, 0, 1, 5, 5'b01110, 5, mem_word(3),  32'd0);
        vec_a[5] = mk(0, 0, 0, 0, 5'b00001, 5, mem_word(3),  mem_word(5));
        vec_a[6] = mk(0, 0, 0, 0, 5'b00000, 5, mem_word(3),  mem_word(5));
        vec_a[7] = mk(1, 9, 1, 6, 5'b10100, 9, mem_word(3),  mem_word(5));
        vec_a[8] = mk(0, 0, 1, 6, 5'b01110, 6, mem_word(9),  mem_word(5));
        vec_a[9] = mk(0, 0, 0, 0, 5'b00001, 6, mem_word(9),  mem_word(6));

        // fetch, dbg, fetch back-to-back on dut_b (READ_LAT=3).
        vec_b[0] = mk(1, 10, 0, 0,  5'b10100, 10, 32'd0,        32'd0);
        vec_b[1] = mk(0, 0,  1, 20, 5'b01100, 20, 32'd0,        32'd0);
        vec_b[2] = mk(1, 30, 0, 0,  5'b10100, 30, 32'd0,        32'd0);
        vec_b[3] = mk(0, 0,  0, 0,  5'b00010, 30, mem_word(10), 32'd0);
        vec_b[4] = mk(0, 0,  0, 0,  5'b00001, 30, mem_word(10), mem_word(20));
        vec_b[5] = mk(0, 0,  0, 0,  5'b00010, 30, mem_word(30), mem_word(20));
        vec_b[6] = mk(0, 0,  0, 0,  5'b00000, 30, mem_word(30), mem_word(20));

        // Reset with requests pending: they must be ignored.
        applyStimulus(1, 1, 10'd3, 1, 10'd4);
        applyStimulus(1, 1, 10'd3, 1, 10'd4);
        checkOutput("reset_state_a", pack_out(fg_a, dg_a, en_a, frv_a, drv_a, ma_a, frd_a, drd_a), 128'd0);
        checkOutput("reset_state_b", pack_out(fg_b, dg_b, en_b, frv_b, drv_b, ma_b, frd_b, drd_b), 128'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, vec_a[i].fetch_req, vec_a[i].fetch_addr, vec_a[i].dbg_req, vec_a[i].dbg_addr);
            checkOutput($sformatf("vec_a[%0d]", i),
                        pack_out(fg_a, dg_a, en_a, frv_a, drv_a, ma_a, frd_a, drd_a),
                        pack_out(vec_a[i].exp_flags[4], vec_a[i].exp_flags[3], vec_a[i].exp_flags[2],
                                 vec_a[i].exp_flags[1], vec_a[i].exp_flags[0], vec_a[i].exp_addr,
                                 vec_a[i].exp_frd, vec_a[i].exp_drd));
        end

`ifdef IMEM_ARB_STATS_EN
        checkOutput("stats_a", {80'd0, sf_a, sd_a, sx_a}, {80'd0, 16'd5, 16'd2, 16'd0});
`endif

        // Continuous contention: dut_a forces debug every 9th cycle,
        // dut_b (guard disabled) never grants debug.
        for (int i = 0; i < 54; i++) begin
            logic [9:0] fa;
            logic       forced;
            logic       resp;
            fa     = 10'(i + 100);
            forced = ((i % 9) == 8);
            resp   = (i > 0) && (((i - 1) % 9) == 8);
            applyStimulus(0, 1, fa, 1, 10'd200);
            checkOutput($sformatf("contend_a[%0d]", i),
                        {120'd0, fg_a, dg_a, drv_a, 5'd0},
                        {120'd0, !forced, forced, resp, 5'd0});
            if (resp) begin
                checkOutput($sformatf("contend_a_drd[%0d]", i), {96'd0, drd_a}, {96'd0, mem_word(10'd200)});
            end
            checkOutput($sformatf("contend_b[%0d]", i), {126'd0, fg_b, dg_b}, {126'd0, 2'b10});
        end

        // Reset in flight on dut_c (READ_LAT=2): the fetch of address 7
        // must never come back.
        applyStimulus(0, 0, 10'd0, 0, 10'd0);
        applyStimulus(0, 1, 10'd7, 0, 10'd0);
        checkOutput("midrst_grant_c", {118'd0, fg_c, en_c, ma_c}, {118'd0, 1'b1, 1'b1, 10'd7});
        applyStimulus(1, 1, 10'd7, 1, 10'd8);
        checkOutput("midrst_during_c", {124'd0, fg_c, dg_c, en_c, frv_c}, 128'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 10'd0, 0, 10'd0);
            checkOutput($sformatf("midrst_after_c[%0d]", i),
                        pack_out(fg_c, dg_c, en_c, frv_c, drv_c, ma_c, frd_c, drd_c), 128'd0);
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, vec_b[i].fetch_req, vec_b[i].fetch_addr, vec_b[i].dbg_req, vec_b[i].dbg_addr);
            checkOutput($sformatf("vec_b[%0d]", i),
                        pack_out(fg_b, dg_b, en_b, frv_b, drv_b, ma_b, frd_b, drd_b),
                        pack_out(vec_b[i].exp_flags[4], vec_b[i].exp_flags[3], vec_b[i].exp_flags[2],
                                 vec_b[i].exp_flags[1], vec_b[i].exp_flags[0], vec_b[i].exp_addr,
                                 vec_b[i].exp_frd, vec_b[i].exp_drd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction-memory block RAM (10-bit word address, 32-bit data, registered output) between two requesters: the CPU fetch stage, and the debug/display read port driven from the board switches.
- Fetch has fixed priority.
- A starvation guard guarantees the debug port a slot.
- A tag pipeline routes each returning word to its owner, with a per-port valid.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, memory data width.
- READ_LAT, 1, memory read latency in cycles (legal 1..4).
- STARVE_LIMIT, 8, consecutive denied debug cycles before debug is forced through; 0 disables the guard.

Ports:
- clk in 1: system clock.
- rst in 1: reset, synchronous, active-high.
- fetch_req in 1: fetch read request.
- fetch_addr in ADDR_W: fetch word address.
- fetch_gnt out 1: fetch granted this cycle.
- fetch_rvalid out 1: fetch_rdata valid.
- fetch_rdata out DATA_W: fetch read data.
- dbg_req in 1: debug read request.
- dbg_addr in ADDR_W: debug word address.
- dbg_gnt out 1: debug granted this cycle.
- dbg_rvalid out 1: dbg_rdata valid.
- dbg_rdata out DATA_W: debug read data.
- mem_en out 1: memory read enable.
- mem_addr out ADDR_W: memory address.
- mem_dout in DATA_W: memory registered output (douta).

Behaviour:
- One clock; reset is synchronous and active-high on rst, clock port clk.
- Arbitration is combinational within the cycle; at most one of fetch_gnt/dbg_gnt is high.
- Normal rule: fetch_req wins; dbg wins only when fetch_req=0.
- Forced rule: when starve_cnt == STARVE_LIMIT (and STARVE_LIMIT != 0) and dbg_req=1, dbg wins even if fetch_req=1. fetch_gnt=0 and the CPU must hold fetch_addr and stall.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - increments each cycle dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIMIT;
  - clears on dbg_gnt=1 or dbg_req=0.
- mem_en = fetch_gnt | dbg_gnt.
- mem_addr = granted port's address; it holds its last value when idle (no glitching to 0).
- Tag pipeline is READ_LAT stages of {valid, owner}, shifted every cycle; stage 0 loads {mem_en, dbg_gnt}.
- fetch_rvalid = last stage valid & owner==fetch; dbg_rvalid = last stage valid & owner==dbg.
- Response latency is exactly READ_LAT cycles after the grant cycle.
- Read data: fetch_rdata and dbg_rdata are registered copies of mem_dout, updated only when their port's rvalid is set, so each port holds its last word between reads.
- Back-to-back grants, including alternating owners, are allowed every cycle with no bubble.
- Reset values: gnts 0, rvalids 0, rdata 0, mem_en 0, mem_addr 0, starve_cnt 0, all tag stages invalid.
- Reset mid-operation discards in-flight reads: no rvalid is asserted for grants issued before or during rst.
- Requests are ignored while rst=1.

Optional Feature:
- Macro IMEM_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_fetch_cnt, 16 bits: fetch grants.
  - stat_dbg_cnt, 16 bits: debug grants.
  - stat_force_cnt, 16 bits: forced debug grants.
- Counters wrap at 2^16 and clear on rst.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package imem_arb_pkg holds:
  - owner encoding OWNER_FETCH=1'b0, OWNER_DBG=1'b1;
  - the tag struct {valid, owner};
  - a default-parameter constant for READ_LAT.
- One natural sub-module: imem_tag_pipe, a parameterised READ_LAT-deep valid/owner shift register with synchronous clear.

Test Plan:
1. Fetch only, READ_LAT=1: fetch_req=1 with addr 0,1,2,3 on consecutive cycles → fetch_gnt=1 each cycle, fetch_rvalid=1 one cycle later with mem word of each address in order, dbg_rvalid never set.
2. Debug only: dbg_req=1, dbg_addr=0x005 → dbg_gnt same cycle, dbg_rvalid next cycle, dbg_rdata=word[5] held after dbg_req drops.
3. Contention, STARVE_LIMIT=8: both requesting continuously → fetch granted 8 cycles, debug forced on the 9th (fetch_gnt=0 that cycle), pattern repeats with period 9.
4. STARVE_LIMIT=0, both requesting for 50 cycles → dbg_gnt never asserted.
5. Reset mid-flight, READ_LAT=2: grant fetch addr 7, assert rst next cycle → no fetch_rvalid afterwards, all outputs at reset values.
6. Alternating owners, READ_LAT=3: fetch, dbg, fetch grants on consecutive cycles → rvalids arrive 3 cycles later in the same order to the correct ports, data matching each address.
